morse_sequencer: RTL and testbench
==================================

// Module: morse_sequencer
// PURPOSE
//  Plays one Morse character on a LED: captures a 10-bit symbol word, then sequences dot/dash/gap timing.
//  Word = 5 symbol pairs, MSB pair first; pair = {valid, long}; valid=0 ends the character.
//  Sits between the CPU output port (word source) and the board LED; owns the timebase (no external divider).
// PARAMETERS
//  TICK_DIV      12500000  clk cycles per Morse time unit (250 ms @ 50 MHz)
//  DOT_UNITS     1         LED-on units for a short symbol
//  DASH_UNITS    3         LED-on units for a long symbol
//  GAP_UNITS     1         LED-off units after every played symbol
//  LETTER_UNITS  3         total off units closing a character (MORSE_LETTER_GAP_EN only); >= GAP_UNITS
//  CNT_W         26        duration counter width; must hold max(DASH,LETTER)*TICK_DIV-1
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  start      in   1   request; sampled only in IDLE
//  morse      in   10  character word, captured on the accepting edge
//  led        out  1   Morse output, 1 = light on
//  dash       out  1   1 while led=1 and current symbol is long
//  busy       out  1   1 in every state except IDLE
//  done       out  1   one-cycle pulse when the character completes
// BEHAVIOUR
//  States: IDLE, FETCH, ON, GAP, LGAP, DONE. All outputs are decoded from registered state (no comb path from inputs).
//  Reset: state=IDLE, shift reg=0, cnt=0, nsym=0; led=0, dash=0, busy=0, done=0.
//  IDLE: start=1 -> load shift reg <= morse, nsym <= 0, go FETCH. start=0 -> stay.
//  FETCH: top pair valid=1 -> ON, cnt <= (long ? DASH_UNITS : DOT_UNITS)*TICK_DIV-1, latch long.
//         valid=0 or nsym==5 -> LGAP if enabled and nsym!=0, else DONE.
//  ON: led=1; cnt==0 -> GAP, cnt <= GAP_UNITS*TICK_DIV-1; else cnt--. LED high exactly units*TICK_DIV cycles.
//  GAP: led=0; cnt==0 -> shift reg <<= 2, nsym++, go FETCH; else cnt--.
//  LGAP: led=0, busy=1; cnt==0 -> DONE; else cnt--.
//  DONE: done=1 for one cycle, then IDLE. A new start is accepted at the earliest on the edge after returning to IDLE.
//  Timing: accept edge E0 -> FETCH; E1 -> ON (led rises). Each FETCH costs one extra led-off cycle between symbols.
//  start while busy: ignored, morse not re-sampled; captured word is stable for the whole character.
//  morse == 0: FETCH -> DONE; led never rises; done at 2nd cycle after accept.
//  All 5 pairs valid: after 5th GAP, nsym==5 ends the character without reading beyond the word.
//  Pairs after the first invalid pair are ignored (e.g. 01_10_... plays nothing).
//  Reset mid-character: immediate IDLE, led=0, no done pulse.
//  cnt is unsigned CNT_W bits; durations are computed at elaboration, no runtime multiply.
// CONFIGURATION
//  MORSE_LETTER_GAP_EN defined: after the last played symbol's GAP, enter LGAP for
//    (LETTER_UNITS-GAP_UNITS)*TICK_DIV cycles (skip LGAP if that is 0), so the total off time = LETTER_UNITS.
//    Not applied when nsym==0.
//  MORSE_LETTER_GAP_EN undefined: LGAP unreachable; FETCH ends directly in DONE.
// TESTING  (TICK_DIV=4, DOT=1, DASH=3, GAP=1, LETTER=3)
//  "A": morse=10'b10_11_00_00_00, start pulse -> led 1 for 4 cycles, 0 for 5, 1 (dash=1) for 12,
//      then 0; done pulses 6 cycles after the dash ends (without MORSE_LETTER_GAP_EN).
//  Same word with MORSE_LETTER_GAP_EN -> done pulses 8 cycles later than above.
//  "0": morse=10'b11_11_11_11_11 -> five 12-cycle led pulses with 5-cycle spacing, done once, busy low afterwards.
//  morse=0, start -> busy high 2 cycles, led never 1, done pulse in cycle 2 after accept.
//  start re-asserted with a different word mid-character -> ignored, output equals the original word.
//  reset asserted during a dash -> led, busy, done 0 immediately; next start plays a full character.

Source files
------------

// File: rtl/morse_sequencer.sv
// Plays one Morse character on a LED from a captured 10-bit word of {valid,long} pairs, MSB pair first.
// Optional MORSE_LETTER_GAP_EN stretches the closing off-time of a played character to LETTER_UNITS.
module morse_sequencer #(
    parameter int TICK_DIV     = 12500000,
    parameter int DOT_UNITS    = 1,
    parameter int DASH_UNITS   = 3,
    parameter int GAP_UNITS    = 1,
    parameter int LETTER_UNITS = 3,
    parameter int CNT_W        = 26
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [9:0] i_morse,
    output logic       o_led,
    output logic       o_dash,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ON    = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_LGAP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Durations are loaded as N-1 so a state lasts exactly N cycles.
    localparam int LGAP_CYC = (LETTER_UNITS - GAP_UNITS) * TICK_DIV;
    localparam logic [CNT_W-1:0] DOT_CNT  = CNT_W'(DOT_UNITS * TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_UNITS * TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_UNITS * TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LGAP_CNT = CNT_W'(LGAP_CYC - 1);

    logic [2:0]       r_state;
    logic [9:0]       r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_nsym;
    logic             r_long;

    logic w_sym_vld;
    logic w_cnt_zero;
    logic w_lgap_go;

    assign w_sym_vld  = r_shift[9] && (r_nsym != 3'd5);
    assign w_cnt_zero = (r_cnt == '0);

`ifdef MORSE_LETTER_GAP_EN
    assign w_lgap_go = (r_nsym != 3'd0) && (LGAP_CYC != 0);
`else
    assign w_lgap_go = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_nsym  <= '0;
            r_long  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_shift <= i_morse;
                        r_nsym  <= 3'd0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_sym_vld) begin
                        r_long  <= r_shift[8];
                        r_cnt   <= r_shift[8] ? DASH_CNT : DOT_CNT;
                        r_state <= S_ON;
                    end else if (w_lgap_go) begin
                        r_cnt   <= LGAP_CNT;
                        r_state <= S_LGAP;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_ON: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= GAP_CNT;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_cnt_zero) begin
                        r_shift <= {r_shift[7:0], 2'b00};
                        r_nsym  <= r_nsym + 3'd1;
                        r_state <= S_FETCH;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_LGAP: begin
                    if (w_cnt_zero) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_led  = (r_state == S_ON);
    assign o_dash = (r_state == S_ON) && r_long;
    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);

endmodule

// File: tb/tb_morse_sequencer.sv
// Randomized bench for morse_sequencer against a per-cycle waveform model built from the symbol timing rules.
module tb_morse_sequencer;

    localparam int T      = 4;
    localparam int DOT    = 1;
    localparam int DASH   = 3;
    localparam int GAP    = 1;
    localparam int LETTER = 3;
`ifdef MORSE_LETTER_GAP_EN
    localparam bit LETTER_EN = 1'b1;
`else
    localparam bit LETTER_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] morse;
    logic       led, dash, busy, done;

    int tests = 0;
    int fails = 0;

    // Expected {led,dash,busy,done} for each cycle after the accepting edge.
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    morse_sequencer #(
        .TICK_DIV(T), .DOT_UNITS(DOT), .DASH_UNITS(DASH),
        .GAP_UNITS(GAP), .LETTER_UNITS(LETTER), .CNT_W(26)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_morse(morse),
        .o_led(led), .o_dash(dash), .o_busy(busy), .o_done(done)
    );

    task automatic build_model(input logic [9:0] w);
        logic [1:0] p;
        int nsym;
        exp_q.delete();
        nsym = 0;
        exp_q.push_back(4'b0010);
        for (int i = 0; i < 5; i++) begin
            p = w[9-2*i -: 2];
            if (!p[1]) break;
            repeat ((p[0] ? DASH : DOT) * T) exp_q.push_back({1'b1, p[0], 2'b10});
            repeat (GAP * T + 1) exp_q.push_back(4'b0010);
            nsym++;
        end
        if (LETTER_EN && nsym > 0)
            repeat ((LETTER - GAP) * T) exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0000);
    endtask

    task automatic play(input string name, input logic [9:0] w, input bit noise);
        logic [3:0] got;
        int n;
        build_model(w);
        n = exp_q.size();
        start = 1'b1;
        morse = w;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            got = {led, dash, busy, done};
            tests++;
            if (got !== exp_q[k]) begin
                fails++;
                $display("FAIL %s word=%b cycle=%0d led/dash/busy/done got=%b exp=%b",
                         name, w, k, got, exp_q[k]);
            end
            if (noise && k < n - 2) begin
                start = 1'($urandom_range(0, 1));
                morse = 10'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        morse = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({led, dash, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_state got=%b exp=0000", {led, dash, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({led, dash, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL idle_after_reset got=%b exp=0000", {led, dash, busy, done});
        end
    endtask

    task automatic test_letter_a;
        play("letter_a", 10'b10_11_00_00_00, 1'b0);
    endtask

    task automatic test_all_dashes;
        play("all_dashes", 10'b11_11_11_11_11, 1'b0);
        play("all_dots", 10'b10_10_10_10_10, 1'b0);
    endtask

    task automatic test_empty_words;
        play("zero_word", 10'b00_00_00_00_00, 1'b0);
        play("invalid_first", 10'b01_10_11_10_11, 1'b0);
        play("stop_mid", 10'b11_10_00_11_11, 1'b0);
    endtask

    task automatic test_start_while_busy;
        play("busy_start_a", 10'b10_11_00_00_00, 1'b1);
        play("busy_start_b", 10'b11_10_10_11_00, 1'b1);
    endtask

    task automatic test_back_to_back;
        play("b2b_first", 10'b10_10_00_00_00, 1'b0);
        play("b2b_second", 10'b11_00_00_00_00, 1'b0);
        play("b2b_third", 10'b00_00_00_00_00, 1'b0);
    endtask

    task automatic test_random;
        logic [9:0] w;
        for (int i = 0; i < 8; i++) begin
            w = 10'($urandom);
            if (i % 4 != 3) w[9] = 1'b1;
            play("random", w, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_char;
        start = 1'b1;
        morse = 10'b11_00_00_00_00;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if ({led, dash, busy} !== 3'b111) begin
            fails++;
            $display("FAIL mid_dash got led/dash/busy=%b exp=111", {led, dash, busy});
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({led, dash, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_mid_char got=%b exp=0000", {led, dash, busy, done});
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({led, dash, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hold got=%b exp=0000", {led, dash, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        play("after_reset", 10'b11_10_11_00_00, 1'b0);
    endtask

    initial begin
        test_reset;
        test_letter_a;
        test_all_dashes;
        test_empty_words;
        test_start_while_busy;
        test_back_to_back;
        test_random;
        test_reset_mid_char;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
